// File: rtl/pec_awfeed_pkg.sv
// Shared sizing defaults, FSM encoding and flag popcount for the PE activation/weight feeder.
package pec_pkg;

  localparam int unsigned BLOCK_DEPTH = 32;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned ACC_WIDTH   = 2*DATA_WIDTH + $clog2(BLOCK_DEPTH*3);

  // Widest flag vector popcount accepts; narrower vectors are zero-extended by the caller.
  localparam int unsigned POP_MAX = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pec_awfeed_if.sv
// Upstream side of the feeder: block header, compressed word writes and result handshake.
interface pec_awfeed_if #(
  parameter int unsigned BLOCK_DEPTH = pec_pkg::BLOCK_DEPTH,
  parameter int unsigned DATA_WIDTH  = pec_pkg::DATA_WIDTH,
  parameter int unsigned ACC_WIDTH   = 2*DATA_WIDTH + $clog2(BLOCK_DEPTH*3)
);
  logic                   I_Blk_Val;
  logic                   O_Blk_Rdy;
  logic [BLOCK_DEPTH-1:0] I_FlgAct;
  logic [BLOCK_DEPTH-1:0] I_FlgWei;
  logic [ACC_WIDTH-1:0]   I_Psum;
  logic                   I_Wr_Val;
  logic                   I_Wr_Sel;
  logic [DATA_WIDTH-1:0]  I_Wr_Data;
  logic                   O_Psum_Val;
  logic                   I_Psum_Rdy;
  logic [ACC_WIDTH-1:0]   O_Psum;
  logic                   O_Err;

  modport master (
    output I_Blk_Val, I_FlgAct, I_FlgWei, I_Psum, I_Wr_Val, I_Wr_Sel, I_Wr_Data, I_Psum_Rdy,
    input  O_Blk_Rdy, O_Psum_Val, O_Psum, O_Err
  );

  modport slave (
    input  I_Blk_Val, I_FlgAct, I_FlgWei, I_Psum, I_Wr_Val, I_Wr_Sel, I_Wr_Data, I_Psum_Rdy,
    output O_Blk_Rdy, O_Psum_Val, O_Psum, O_Err
  );
endinterface

// File: rtl/pec_awfeed_awbuf_rf.sv
// Flop register file holding one block's compressed words: one write port, one async read port.
module awbuf_rf #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pec_awfeed.sv
// Feeds compressed activation/weight words to the sparse MAC and returns its
// accumulated partial sum, one flag block at a time.
module pec_awfeed #(
  parameter int unsigned BLOCK_DEPTH = pec_pkg::BLOCK_DEPTH,
  parameter int unsigned DATA_WIDTH  = pec_pkg::DATA_WIDTH,
  parameter int unsigned ACC_WIDTH   = 2*DATA_WIDTH + $clog2(BLOCK_DEPTH*3)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  pec_awfeed_if.slave                    up,
  output logic                           PECMAC_Sta,
  output logic [BLOCK_DEPTH-1:0]         PECMAC_FlgAct,
  output logic [BLOCK_DEPTH-1:0]         PECMAC_FlgWei,
  output logic [ACC_WIDTH-1:0]           MACMAC_Mac,
  output logic [DATA_WIDTH-1:0]          PECMAC_Act,
  output logic [DATA_WIDTH-1:0]          PECMAC_Wei,
  output logic                           PECMAC_ActWei_Val,
  input  logic                           MACAW_ValOffset,
  input  logic [$clog2(BLOCK_DEPTH)-1:0] MACAW_OffsetAct,
  input  logic [$clog2(BLOCK_DEPTH)-1:0] MACAW_OffsetWei,
  input  logic                           MACPEC_Fnh,
  input  logic [ACC_WIDTH-1:0]           MACCNV_Mac
);
  import pec_pkg::*;

  localparam int unsigned AW = $clog2(BLOCK_DEPTH);
  localparam int unsigned CW = AW + 1;

  state_t                state, state_nx;
  logic [CW-1:0]         n_act, n_wei, cnt_act, cnt_wei;
  logic                  run_seen, err;
  logic [ACC_WIDTH-1:0]  psum_q;
  logic                  wr_act, wr_wei, act_ok, wei_ok;
  logic [DATA_WIDTH-1:0] rd_act, rd_wei;

  assign wr_act = (state == LOAD) && up.I_Wr_Val && !up.I_Wr_Sel && (cnt_act < n_act);
  assign wr_wei = (state == LOAD) && up.I_Wr_Val &&  up.I_Wr_Sel && (cnt_wei < n_wei);
  assign act_ok = {1'b0, MACAW_OffsetAct} < cnt_act;
  assign wei_ok = {1'b0, MACAW_OffsetWei} < cnt_wei;

  awbuf_rf #(.DEPTH(BLOCK_DEPTH), .WIDTH(DATA_WIDTH)) u_act_buf (
    .clk(clk), .rst_n(rst_n), .we(wr_act), .waddr(cnt_act[AW-1:0]), .wdata(up.I_Wr_Data),
    .raddr(MACAW_OffsetAct), .rdata(rd_act)
  );

  awbuf_rf #(.DEPTH(BLOCK_DEPTH), .WIDTH(DATA_WIDTH)) u_wei_buf (
    .clk(clk), .rst_n(rst_n), .we(wr_wei), .waddr(cnt_wei[AW-1:0]), .wdata(up.I_Wr_Data),
    .raddr(MACAW_OffsetWei), .rdata(rd_wei)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    up.O_Blk_Rdy      = 1'b0;
    up.O_Psum_Val     = 1'b0;
    PECMAC_Sta        = 1'b0;
    PECMAC_ActWei_Val = 1'b0;
    unique case (state)
      IDLE: begin
        up.O_Blk_Rdy = 1'b1;
        if (up.I_Blk_Val) state_nx = LOAD;
      end
      // Registered counts are compared, so an empty block still spends one cycle here.
      LOAD:  if (cnt_act == n_act && cnt_wei == n_wei) state_nx = START;
      START: begin
        PECMAC_Sta = 1'b1;
        state_nx   = RUN;
      end
      RUN: begin
        PECMAC_ActWei_Val = 1'b1;
        if (run_seen && MACPEC_Fnh) state_nx = DRAIN;
      end
      DRAIN: state_nx = DONE;
      DONE: begin
        up.O_Psum_Val = 1'b1;
        if (up.I_Psum_Rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    PECMAC_Act = '0;
    PECMAC_Wei = '0;
    if (state == RUN) begin
      if (act_ok) PECMAC_Act = rd_act;
      if (wei_ok) PECMAC_Wei = rd_wei;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PECMAC_FlgAct <= '0;
      PECMAC_FlgWei <= '0;
      MACMAC_Mac    <= '0;
      n_act         <= '0;
      n_wei         <= '0;
      cnt_act       <= '0;
      cnt_wei       <= '0;
      run_seen      <= 1'b0;
      err           <= 1'b0;
      psum_q        <= '0;
    end else begin
      run_seen <= (state == RUN);
      unique case (state)
        IDLE: if (up.I_Blk_Val) begin
          PECMAC_FlgAct <= up.I_FlgAct;
          PECMAC_FlgWei <= up.I_FlgWei;
          MACMAC_Mac    <= up.I_Psum;
          n_act         <= CW'(popcount(POP_MAX'(up.I_FlgAct)));
          n_wei         <= CW'(popcount(POP_MAX'(up.I_FlgWei)));
          cnt_act       <= '0;
          cnt_wei       <= '0;
        end
        LOAD: begin
          if (wr_act) cnt_act <= cnt_act + CW'(1);
          if (wr_wei) cnt_wei <= cnt_wei + CW'(1);
          if (up.I_Wr_Val && !wr_act && !wr_wei) err <= 1'b1;
        end
        RUN:   if (MACAW_ValOffset && (!act_ok || !wei_ok)) err <= 1'b1;
        DRAIN: psum_q <= MACCNV_Mac;
        default: ;
      endcase
    end
  end

  assign up.O_Psum = psum_q;
  assign up.O_Err  = err;
endmodule

// File: tb/tb_pec_awfeed.sv
// Randomized self-checking bench for pec_awfeed with a behavioural MAC agent and sum-of-products model.
module tb_pec_awfeed;
  localparam int unsigned BD   = 32;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = $clog2(BD);
  localparam int unsigned ACCW = 2*DW + $clog2(BD*3);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pec_awfeed_if #(.BLOCK_DEPTH(BD), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) bus ();

  logic            sta, val, voff, fnh;
  logic [BD-1:0]   fa_o, fw_o;
  logic [ACCW-1:0] mac_o, cnv;
  logic [DW-1:0]   act_o, wei_o;
  logic [AW-1:0]   offa, offw;

  pec_awfeed #(.BLOCK_DEPTH(BD), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .up(bus),
    .PECMAC_Sta(sta), .PECMAC_FlgAct(fa_o), .PECMAC_FlgWei(fw_o), .MACMAC_Mac(mac_o),
    .PECMAC_Act(act_o), .PECMAC_Wei(wei_o), .PECMAC_ActWei_Val(val),
    .MACAW_ValOffset(voff), .MACAW_OffsetAct(offa), .MACAW_OffsetWei(offw),
    .MACPEC_Fnh(fnh), .MACCNV_Mac(cnv)
  );

  int checks = 0;
  int errors = 0;
  int sta_seen = 0;

  logic [BD-1:0]        cur_fa, cur_fw;
  int                   cur_psum;
  logic signed [DW-1:0] cur_acts[$];
  logic signed [DW-1:0] cur_weis[$];
  int                   pair_a[$];
  int                   pair_w[$];

  always @(negedge clk) if (sta === 1'b1) sta_seen++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    bus.I_Blk_Val = 1'b0; bus.I_FlgAct = '0; bus.I_FlgWei = '0; bus.I_Psum = '0;
    bus.I_Wr_Val = 1'b0; bus.I_Wr_Sel = 1'b0; bus.I_Wr_Data = '0; bus.I_Psum_Rdy = 1'b0;
    voff = 1'b0; fnh = 1'b0; offa = '0; offw = '0; cnv = '0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Expected result: incoming psum plus products where both flags are set; the word for
  // flag bit i sits at the count of set flags below i in its compressed list.
  function automatic int ref_psum();
    int acc;
    logic [BD-1:0] below;
    acc = cur_psum;
    for (int i = 0; i < BD; i++) begin
      below = (BD'(1) << i) - BD'(1);
      if (cur_fa[i] && cur_fw[i])
        acc += int'(cur_acts[$countones(cur_fa & below)]) * int'(cur_weis[$countones(cur_fw & below)]);
    end
    return acc;
  endfunction

  function automatic void random_block();
    cur_fa = $urandom() & $urandom();
    cur_fw = $urandom() | $urandom();
    cur_psum = int'($urandom_range(0, 2000)) - 1000;
    cur_acts.delete();
    cur_weis.delete();
    for (int i = 0; i < $countones(cur_fa); i++) cur_acts.push_back(DW'($urandom_range(0, 255)));
    for (int i = 0; i < $countones(cur_fw); i++) cur_weis.push_back(DW'($urandom_range(0, 255)));
  endfunction

  task automatic do_header(output bit to);
    int n;
    n = 0;
    while (bus.O_Blk_Rdy !== 1'b1 && n < 20) begin tick; n++; end
    to = (bus.O_Blk_Rdy !== 1'b1);
    bus.I_Blk_Val = 1'b1;
    bus.I_FlgAct  = cur_fa;
    bus.I_FlgWei  = cur_fw;
    bus.I_Psum    = ACCW'(cur_psum);
    tick;
    bus.I_Blk_Val = 1'b0;
  endtask

  task automatic load_block(input bit extra_act);
    int ia, iw;
    ia = 0; iw = 0;
    while (ia < cur_acts.size() || iw < cur_weis.size()) begin
      bus.I_Wr_Val = 1'b1;
      if (iw >= cur_weis.size() || (ia < cur_acts.size() && $urandom_range(0, 1) == 0)) begin
        bus.I_Wr_Sel = 1'b0; bus.I_Wr_Data = cur_acts[ia]; ia++;
      end else begin
        bus.I_Wr_Sel = 1'b1; bus.I_Wr_Data = cur_weis[iw]; iw++;
      end
      tick;
    end
    if (extra_act) begin
      bus.I_Wr_Val = 1'b1; bus.I_Wr_Sel = 1'b0; bus.I_Wr_Data = 8'sd99;
      tick;
    end
    bus.I_Wr_Val = 1'b0;
  endtask

  // Behavioural MAC: walks the flag pairs, multiplies the fed words, then raises Fnh.
  task automatic mac_run(input bit probe, output bit to, output int start_mac,
                         output bit first_ignored, output logic drain_val,
                         output logic [DW-1:0] probe_act, output logic [DW-1:0] probe_wei);
    int n, acc, ia, iw;
    pair_a.delete(); pair_w.delete(); ia = 0; iw = 0;
    for (int i = 0; i < BD; i++) begin
      if (cur_fa[i] && cur_fw[i]) begin pair_a.push_back(ia); pair_w.push_back(iw); end
      if (cur_fa[i]) ia++;
      if (cur_fw[i]) iw++;
    end
    first_ignored = 1'b0; drain_val = 1'bx; probe_act = 'x; probe_wei = 'x; start_mac = 0;
    n = 0;
    while (sta !== 1'b1 && n < 20) begin tick; n++; end
    to = (sta !== 1'b1);
    if (to) return;
    start_mac = int'($signed(mac_o));
    acc = start_mac;
    tick;
    if (pair_a.size() == 0 && !probe) begin
      fnh = 1'b1;
      tick;
      first_ignored = (val === 1'b1);
    end
    for (int k = 0; k < pair_a.size(); k++) begin
      voff = 1'b1; offa = AW'(pair_a[k]); offw = AW'(pair_w[k]);
      #1;
      acc += int'($signed(act_o)) * int'($signed(wei_o));
      tick;
    end
    if (probe) begin
      voff = 1'b1; offa = AW'(5); offw = '0;
      #1;
      probe_act = act_o; probe_wei = wei_o;
      tick;
    end
    voff = 1'b0; cnv = ACCW'(acc); fnh = 1'b1;
    tick;
    drain_val = val;
    fnh = 1'b0;
  endtask

  task automatic take_result(output bit to, output logic [ACCW-1:0] res);
    int n;
    n = 0;
    while (bus.O_Psum_Val !== 1'b1 && n < 10) begin tick; n++; end
    to = (bus.O_Psum_Val !== 1'b1);
    res = bus.O_Psum;
    bus.I_Psum_Rdy = 1'b1;
    tick;
    bus.I_Psum_Rdy = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    checks++; if (bus.O_Blk_Rdy !== 1'b1) begin errors++; $display("FAIL reset_blk_rdy: got %b expected 1", bus.O_Blk_Rdy); end
    checks++; if ({sta, val, bus.O_Psum_Val, bus.O_Err} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {sta, val, bus.O_Psum_Val, bus.O_Err}); end
    checks++; if ({bus.O_Psum, mac_o, fa_o, fw_o, act_o, wei_o} !== '0) begin errors++; $display("FAIL reset_data: got nonzero data outputs, expected all 0"); end
  endtask

  task automatic test_example;
    bit to, fi, to2; int sm; logic dv; logic [DW-1:0] pa, pw; logic [ACCW-1:0] res;
    cur_fa = BD'(4'b1011); cur_fw = BD'(4'b0110); cur_psum = 10;
    cur_acts = {8'sd3, -8'sd2, 8'sd5}; cur_weis = {8'sd4, 8'sd7};
    sta_seen = 0;
    do_header(to);
    checks++; if (fa_o !== cur_fa || fw_o !== cur_fw) begin errors++; $display("FAIL example_flags: got %h/%h expected %h/%h", fa_o, fw_o, cur_fa, cur_fw); end
    load_block(1'b0);
    mac_run(1'b0, to2, sm, fi, dv, pa, pw);
    take_result(to, res);
    checks++; if (to || to2) begin errors++; $display("FAIL example_timeout: got timeout expected handshake"); end
    checks++; if (sm != 10) begin errors++; $display("FAIL example_mac_start: got %0d expected 10", sm); end
    checks++; if (sta_seen != 1) begin errors++; $display("FAIL example_sta_pulses: got %0d expected 1", sta_seen); end
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL example_drain_val: got %b expected 0", dv); end
    checks++; if ($signed(res) != 2 || ref_psum() != 2) begin errors++; $display("FAIL example_psum: got %0d expected 2", $signed(res)); end
  endtask

  task automatic test_empty;
    bit to, fi, to2; int sm; logic dv; logic [DW-1:0] pa, pw; logic [ACCW-1:0] res;
    cur_fa = '0; cur_fw = '0; cur_psum = -7; cur_acts.delete(); cur_weis.delete();
    sta_seen = 0;
    do_header(to);
    checks++; if (sta !== 1'b0 || bus.O_Blk_Rdy !== 1'b0) begin errors++; $display("FAIL empty_load: got sta=%b rdy=%b expected 0/0", sta, bus.O_Blk_Rdy); end
    tick;
    checks++; if (sta !== 1'b1) begin errors++; $display("FAIL empty_load_len: got sta=%b expected 1 after one LOAD cycle", sta); end
    mac_run(1'b0, to2, sm, fi, dv, pa, pw);
    take_result(to, res);
    checks++; if (to || to2) begin errors++; $display("FAIL empty_timeout: got timeout expected handshake"); end
    checks++; if (!fi) begin errors++; $display("FAIL empty_fnh_first_cycle: got left RUN expected Fnh ignored"); end
    checks++; if ($signed(res) != ref_psum()) begin errors++; $display("FAIL empty_psum: got %0d expected %0d", $signed(res), ref_psum()); end
    checks++; if (bus.O_Err !== 1'b0 || sta_seen != 1) begin errors++; $display("FAIL empty_err_sta: got err=%b sta=%0d expected 0/1", bus.O_Err, sta_seen); end
  endtask

  task automatic test_overflow;
    bit to, fi, to2; int sm; logic dv; logic [DW-1:0] pa, pw; logic [ACCW-1:0] res;
    cur_fa = BD'(3'b111); cur_fw = BD'(3'b101); cur_psum = 20;
    cur_acts = {DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255))};
    cur_weis = {DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255))};
    do_header(to);
    load_block(1'b1);
    mac_run(1'b0, to2, sm, fi, dv, pa, pw);
    take_result(to, res);
    checks++; if (to || to2) begin errors++; $display("FAIL overflow_timeout: got timeout expected handshake"); end
    checks++; if (bus.O_Err !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b expected 1", bus.O_Err); end
    checks++; if ($signed(res) != ref_psum()) begin errors++; $display("FAIL overflow_psum: got %0d expected %0d", $signed(res), ref_psum()); end
    apply_reset;
    checks++; if (bus.O_Err !== 1'b0) begin errors++; $display("FAIL overflow_err_clear: got %b expected 0", bus.O_Err); end
  endtask

  task automatic test_oob_offset;
    bit to, fi, to2; int sm; logic dv; logic [DW-1:0] pa, pw; logic [ACCW-1:0] res;
    cur_fa = BD'(3'b111); cur_fw = BD'(3'b101); cur_psum = -3;
    cur_acts = {DW'($urandom_range(1, 255)), DW'($urandom_range(1, 255)), DW'($urandom_range(1, 255))};
    cur_weis = {DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255))};
    do_header(to);
    load_block(1'b0);
    mac_run(1'b1, to2, sm, fi, dv, pa, pw);
    take_result(to, res);
    checks++; if (to || to2) begin errors++; $display("FAIL oob_timeout: got timeout expected handshake"); end
    checks++; if (pa !== '0) begin errors++; $display("FAIL oob_act: got %h expected 00", pa); end
    checks++; if (pw !== cur_weis[0]) begin errors++; $display("FAIL oob_wei_lane: got %h expected %h", pw, cur_weis[0]); end
    checks++; if (bus.O_Err !== 1'b1) begin errors++; $display("FAIL oob_err: got %b expected 1", bus.O_Err); end
    checks++; if ($signed(res) != ref_psum()) begin errors++; $display("FAIL oob_psum: got %0d expected %0d", $signed(res), ref_psum()); end
    apply_reset;
  endtask

  task automatic test_backpressure;
    bit to, fi, to2; int sm, n; logic dv; logic [DW-1:0] pa, pw; logic [ACCW-1:0] held;
    random_block();
    do_header(to);
    load_block(1'b0);
    mac_run(1'b0, to2, sm, fi, dv, pa, pw);
    n = 0;
    while (bus.O_Psum_Val !== 1'b1 && n < 10) begin tick; n++; end
    checks++; if (to || to2 || bus.O_Psum_Val !== 1'b1) begin errors++; $display("FAIL bp_timeout: got timeout expected O_Psum_Val"); end
    held = bus.O_Psum;
    checks++; if ($signed(held) != ref_psum()) begin errors++; $display("FAIL bp_psum: got %0d expected %0d", $signed(held), ref_psum()); end
    bus.I_Blk_Val = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if (bus.O_Psum_Val !== 1'b1 || bus.O_Psum !== held || bus.O_Blk_Rdy !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got val=%b psum=%0d rdy=%b expected 1/%0d/0", c, bus.O_Psum_Val, $signed(bus.O_Psum), bus.O_Blk_Rdy, $signed(held));
      end
    end
    bus.I_Blk_Val = 1'b0;
    bus.I_Psum_Rdy = 1'b1;
    tick;
    bus.I_Psum_Rdy = 1'b0;
    checks++; if (bus.O_Blk_Rdy !== 1'b1 || bus.O_Psum_Val !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b val=%b expected 1/0", bus.O_Blk_Rdy, bus.O_Psum_Val); end
  endtask

  task automatic test_reset_in_run;
    bit to, fi, to2; int sm, n; logic dv; logic [DW-1:0] pa, pw; logic [ACCW-1:0] res;
    random_block();
    do_header(to);
    load_block(1'b0);
    n = 0;
    while (sta !== 1'b1 && n < 20) begin tick; n++; end
    tick;
    checks++; if (val !== 1'b1) begin errors++; $display("FAIL rr_in_run: got val=%b expected 1", val); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.O_Blk_Rdy !== 1'b1 || val !== 1'b0 || bus.O_Psum_Val !== 1'b0) begin
      errors++; $display("FAIL rr_async: got rdy=%b val=%b psum_val=%b expected 1/0/0", bus.O_Blk_Rdy, val, bus.O_Psum_Val);
    end
    tick;
    rst_n = 1'b1;
    repeat (3) tick;
    checks++; if (bus.O_Psum_Val !== 1'b0 || bus.O_Blk_Rdy !== 1'b1) begin errors++; $display("FAIL rr_abandon: got psum_val=%b rdy=%b expected 0/1", bus.O_Psum_Val, bus.O_Blk_Rdy); end
    random_block();
    do_header(to);
    load_block(1'b0);
    mac_run(1'b0, to2, sm, fi, dv, pa, pw);
    take_result(to, res);
    checks++; if (to || to2 || $signed(res) != ref_psum()) begin errors++; $display("FAIL rr_next_block: got %0d expected %0d", $signed(res), ref_psum()); end
  endtask

  task automatic test_random;
    bit to, fi, to2; int sm; logic dv; logic [DW-1:0] pa, pw; logic [ACCW-1:0] res;
    for (int b = 0; b < 8; b++) begin
      random_block();
      sta_seen = 0;
      do_header(to);
      load_block(1'b0);
      mac_run(1'b0, to2, sm, fi, dv, pa, pw);
      take_result(to, res);
      checks++;
      if (to || to2 || $signed(res) != ref_psum() || sta_seen != 1) begin
        errors++; $display("FAIL random%0d: got psum=%0d sta=%0d expected %0d/1", b, $signed(res), sta_seen, ref_psum());
      end
    end
    checks++; if (bus.O_Err !== 1'b0) begin errors++; $display("FAIL random_err: got %b expected 0", bus.O_Err); end
  endtask

  initial begin
    test_reset;
    test_example;
    test_empty;
    test_overflow;
    test_oob_offset;
    test_backpressure;
    test_reset_in_run;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1);
  end
endmodule
